// File: rtl/nios_display_pkg.sv
// nios_display_pkg: shared register map, FSM encoding and counter width for the display scanner
package nios_display_pkg;
   localparam int DWELL_W = 20;
   localparam logic [2:0] ADDR_DIGIT0 = 3'd0;
   localparam logic [2:0] ADDR_CTRL   = 3'd4;
   localparam logic [2:0] ADDR_DWELL  = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;
   typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;
endpackage

// File: rtl/nios_display_scan_if.sv
// nios_display_scan_if: Avalon-MM slave bus of the display scanner
interface nios_display_scan_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_display_timer.sv
// nios_display_timer: loadable down-counter that holds at zero
module nios_display_timer
   import nios_display_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   output logic [DWELL_W-1:0] cnt,
   output logic               zero
);
   assign zero = cnt == '0;
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (!zero) cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/nios_display_scan.sv
// nios_display_scan: Avalon-MM register file scanning NUM_DIGITS 7-segment patterns onto one segment bus
module nios_display_scan
   import nios_display_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DWELL_DEFAULT  = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   nios_display_scan_if.slave    bus,
   output logic [7:0]            seg_out,
   output logic [NUM_DIGITS-1:0] dig_sel
);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
   logic [7:0]            digit [NUM_DIGITS];
   logic                  en, frame_done, wr, is_digit, load, wrap, zero;
   logic [DWELL_W-1:0]    dwell, load_val, cnt;
   logic [IDX_W-1:0]      idx, idx_nxt, a_idx;
   logic [7:0]            pat_nxt, shadow, seg_nxt;
   logic [NUM_DIGITS-1:0] dig_nxt, one_hot;
   state_t                state, state_nxt;
   assign wr       = bus.chipselect & ~bus.write_n;
   assign a_idx    = bus.address[IDX_W-1:0];
   assign is_digit = bus.address < ADDR_CTRL && int'(bus.address) < NUM_DIGITS;
   assign bus.readdata = bus.address == ADDR_CTRL   ? {31'b0, en} :
                         bus.address == ADDR_DWELL  ? {{(32-DWELL_W){1'b0}}, dwell} :
                         bus.address == ADDR_STATUS ? {23'b0, frame_done, {(8-IDX_W){1'b0}}, idx} :
                         is_digit                   ? {24'b0, digit[a_idx]} : '0;
   nios_display_timer u_timer (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val), .cnt(cnt), .zero(zero)
   );
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      load_val  = dwell - 1'b1;
      wrap      = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
      end else if (state == IDLE) begin
         state_nxt = DRIVE;
         load      = 1'b1;
      end else if (zero && state == DRIVE) begin
         state_nxt = BLANK;
         load      = 1'b1;
         load_val  = DWELL_W'(BLANK_CYCLES - 1);
      end else if (zero) begin
         state_nxt = DRIVE;
         load      = 1'b1;
         wrap      = idx == IDX_W'(NUM_DIGITS - 1);
         idx_nxt   = wrap ? '0 : idx + 1'b1;
      end
      // the pattern is captured only on DRIVE entry so mid-dwell writes cannot glitch the display
      pat_nxt = (load && state_nxt == DRIVE) ? digit[idx_nxt] : shadow;
      one_hot = NUM_DIGITS'(1) << idx_nxt;
      seg_nxt = state_nxt != DRIVE ? SEG_OFF : (SEG_ACTIVE_LOW != 0) ? ~pat_nxt : pat_nxt;
      dig_nxt = state_nxt != DRIVE ? DIG_OFF : (DIG_ACTIVE_LOW != 0) ? ~one_hot : one_hot;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         digit      <= '{default: '0};
         en         <= 1'b0;
         dwell      <= DWELL_W'(DWELL_DEFAULT);
         frame_done <= 1'b0;
         state      <= IDLE;
         idx        <= '0;
         shadow     <= '0;
         seg_out    <= SEG_OFF;
         dig_sel    <= DIG_OFF;
      end else begin
         if (wr && is_digit) digit[a_idx] <= bus.writedata[7:0];
         if (wr && bus.address == ADDR_CTRL) en <= bus.writedata[0];
         if (wr && bus.address == ADDR_DWELL)
            dwell <= bus.writedata[DWELL_W-1:0] == '0 ? DWELL_W'(1) : bus.writedata[DWELL_W-1:0];
         frame_done <= wrap | (frame_done & ~(wr && bus.address == ADDR_STATUS));
         state      <= state_nxt;
         idx        <= idx_nxt;
         shadow     <= pat_nxt;
         seg_out    <= seg_nxt;
         dig_sel    <= dig_nxt;
      end
   end
endmodule
